// File: rtl/tick_bcd_counter_pkg.sv
// tick_bcd_counter_pkg: shared BCD widths, default modulus and integer-to-BCD helper
package tick_bcd_counter_pkg;
    localparam int BCD_W       = 4;
    localparam int DEFAULT_MOD = 60;

    // Converts an integer 0..99 into two packed BCD digits {tens, ones}.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction
endpackage

// File: rtl/tick_bcd_counter_sync_edge_detect.sv
// sync_edge_detect: synchronises an asynchronous level and pulses for one clk cycle on its rising edge
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   async_in   asynchronous input level
//   rise_pulse high for one cycle per rising edge of async_in
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: two-digit BCD up/down modulo counter advanced once per divided-clock rising edge
//   clk, rst_n        system clock, asynchronous active-low reset
//   div_clk_in        divided clock, sampled as asynchronous data
//   en, up_dn         count enable, direction (1 = up)
//   load, load_val    synchronous load of {tens, ones} BCD value
//   bcd_tens/ones     registered digits
//   tick, wrap        count-update pulse, modulo wrap pulse
//   load_err          pulse when a load value is rejected
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int MOD         = DEFAULT_MOD,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk_in,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [7:0]       load_val,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             tick,
    output logic             wrap,
    output logic             load_err
);
    localparam logic [7:0] MAX_BCD = to_bcd(MOD - 1);

    logic       edge_c;
    logic [6:0] load_bin;
    logic       load_ok;
    logic       step;
    logic       at_max;
    logic       at_zero;
    logic [7:0] cur;
    logic [7:0] nxt;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (div_clk_in),
        .rise_pulse (edge_c)
    );

    assign cur      = {bcd_tens, bcd_ones};
    assign at_max   = cur == MAX_BCD;
    assign at_zero  = cur == 8'h00;
    // Binary value is only meaningful once both nibbles are known to be decimal.
    assign load_bin = 7'(load_val[7:4]) * 7'd10 + 7'(load_val[3:0]);
    assign load_ok  = load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9 && load_bin < 7'(MOD);
    assign step     = ~load & edge_c & en;

    always_comb begin
        nxt = up_dn ? (at_max ? 8'h00 : bcd_ones == 4'd9 ? {bcd_tens + 4'd1, 4'd0} : {bcd_tens, bcd_ones + 4'd1})
                    : (at_zero ? MAX_BCD : bcd_ones == 4'd0 ? {bcd_tens - 4'd1, 4'd9} : {bcd_tens, bcd_ones - 4'd1});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bcd_tens, bcd_ones} <= 8'h00;
            tick                 <= 1'b0;
            wrap                 <= 1'b0;
            load_err             <= 1'b0;
        end else begin
            {bcd_tens, bcd_ones} <= (load && load_ok) ? load_val : step ? nxt : cur;
            tick                 <= step;
            wrap                 <= step & (up_dn ? at_max : at_zero);
            load_err             <= load & ~load_ok;
        end
    end
endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Consumes the slow divided clock produced by the 27-bit frequency divider and drives a two-digit BCD up/down counter for the seven-segment display stage.
- Treats the divided clock strictly as data on the system clock:
  - synchronises it;
  - detects its rising edge;
  - advances the count once per edge.
- Supports enable, direction, synchronous load and modulo wrap with carry/borrow pulse.

Parameters:
- MOD, 60, count modulus; count range 0..MOD-1; legal 2..100
- SYNC_STAGES, 2, synchroniser flops on div_clk_in; legal 2..3

Ports:
- clk  input  1  system clock; all flops on posedge
- rst_n  input  1  asynchronous active-low reset
- div_clk_in  input  1  divided clock from the divider stage, treated as asynchronous data
- en  input  1  count enable; sampled on the tick cycle
- up_dn  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_val  input  8  {tens[3:0], ones[3:0]} BCD value to load
- bcd_tens  output  4  tens digit, registered
- bcd_ones  output  4  ones digit, registered
- tick  output  1  one-cycle pulse, coincident with each count update
- wrap  output  1  one-cycle pulse on MOD-1->0 (up) or 0->MOD-1 (down)
- load_err  output  1  one-cycle pulse when load_val is rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - bcd_tens=0, bcd_ones=0, tick=0, wrap=0, load_err=0.
  - All synchroniser and edge flops cleared.
  - Applies mid-operation with no glitch recovery needed.
- Synchroniser:
  - div_clk_in passes through SYNC_STAGES flops, then one history flop.
  - Internal edge_c = sync_out & ~hist.
- Latency (SYNC_STAGES=2): div_clk_in high before posedge k gives
  - edge_c high during cycle k+1..k+2;
  - count update at posedge k+2;
  - tick high for cycle k+2..k+3.
- One tick per div_clk_in rising edge. Falling edges are ignored. A high level held for N cycles yields exactly one edge_c.
- Priority per cycle is load > count:
  - load=1, load_val valid (each nibble <=9 and value <MOD):
    - digits <= load_val;
    - tick=0, wrap=0.
  - load=1, load_val invalid:
    - digits unchanged;
    - load_err=1 for one cycle;
    - a coincident edge_c is dropped.
  - load=0, edge_c=1, en=1, up_dn=1:
    - ones+1;
    - ones 9->0 carries into tens;
    - value MOD-1 -> 00, wrap=1.
  - load=0, edge_c=1, en=1, up_dn=0:
    - ones-1;
    - ones 0->9 borrows from tens;
    - value 00 -> MOD-1 in BCD, wrap=1.
  - edge_c=1, en=0:
    - count held, tick=0;
    - edge consumed, no backlog.
- tick, wrap and load_err are registered and never high more than one cycle per event.
- Digits are always valid BCD and always <MOD after reset. The MOD-1 BCD constant is computed at elaboration.
- up_dn change mid-stream takes effect on the next edge_c; no extra step.
- Arithmetic is per-digit 4-bit. There is no binary intermediate wider than 7 bits.

Decomposition:
- Shared package:
  - BCD_W=4;
  - DEFAULT_MOD=60;
  - function to convert integer 0..99 to 8-bit BCD, used for the MOD-1 constant and by the bench.
- One sub-module: sync_edge_detect.
  - Parameter SYNC_STAGES.
  - Ports clk, rst_n, async_in, rise_pulse.
  - Reused by later debounce/pushbutton stages.
- Counter datapath and priority logic stay in tick_bcd_counter.

Test Plan:
- Reset then 3 div_clk_in rising edges, en=1, up_dn=1 -> digits 00->01->02->03; each tick exactly one cycle, 2-cycle latency after the synchroniser sees the edge.
- load 0x59, then one edge, up -> digits 00, wrap=1 and tick=1 same cycle. Then load 0x00, one edge, down -> digits 0x59, wrap=1.
- Count up from 0x08 over two edges -> 0x09 then 0x10; no wrap.
- load 0x5A and separately load 0x60 -> digits unchanged, load_err=1 one cycle each. Then load 0x27 -> 0x27, load_err=0.
- en=0 across 4 edges, then en=1 for 1 edge -> count advances by exactly 1. div_clk_in held high 20 cycles -> single tick.
- Edge and valid load 0x33 in the same cycle -> digits 0x33, tick=0. Assert rst_n low mid-count at 0x42 -> all outputs 0 immediately (asynchronous), first tick after release yields 0x01.
